// File: rtl/shift_arbiter.sv
// Two-port arbiter sharing one 32-bit SLL/SRL/SRA shifter, with a registered, tagged result stage.
// Define SHIFT_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.

module shift32 (
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [4:0]  b_i,
  output logic [31:0] y_o
);
  // op[1] selects SRA, so 2'b11 is also an arithmetic shift
  always_comb begin
    y_o = a_i << b_i;
    if (op_i[1])      y_o = $unsigned($signed(a_i) >>> b_i);
    else if (op_i[0]) y_o = a_i >> b_i;
  end
endmodule

module shift_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [4:0]  req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [4:0]  req1_b,
  output logic        req1_ready,
  output logic        resp_valid,
  output logic        resp_port,
  output logic [31:0] resp_data,
  input  logic        resp_ready
);
  logic [1:0]        vld, gnt, rdy;
  logic [1:0][1:0]   op;
  logic [1:0][31:0]  a;
  logic [1:0][4:0]   b;

  logic        resp_valid_q, resp_valid_d;
  logic        resp_port_q, resp_port_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        last_grant_q, last_grant_d;
  logic        slot_free, xfer, sel;
  logic [31:0] sh_y;

  assign vld = {req1_valid, req0_valid};
  assign op  = {req1_op, req0_op};
  assign a   = {req1_a, req0_a};
  assign b   = {req1_b, req0_b};

  assign slot_free = !resp_valid_q || resp_ready;

  always_comb begin
    gnt = 2'b00;
`ifdef SHIFT_ARB_RR_EN
    if (&vld) gnt[~last_grant_q] = 1'b1;
    else      gnt = vld;
`else
    gnt[0] = vld[0];
    gnt[1] = vld[1] && !vld[0];
`endif
  end

  // Readys are forced low in the reset cycle so no transfer can slip through
  assign rdy        = (slot_free && !reset) ? gnt : 2'b00;
  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];

  assign xfer = |(vld & rdy);
  assign sel  = rdy[1];

  shift32 u_shift (
    .op_i (op[sel]),
    .a_i  (a[sel]),
    .b_i  (b[sel]),
    .y_o  (sh_y)
  );

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_port_d  = resp_port_q;
    resp_data_d  = resp_data_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      resp_valid_d = 1'b1;
      resp_port_d  = sel;
      resp_data_d  = sh_y;
      last_grant_d = sel;
    end else if (slot_free) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_port_q  <= 1'b0;
      resp_data_q  <= 32'h0;
      last_grant_q <= 1'b1;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
      resp_data_q  <= resp_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_port  = resp_port_q;
  assign resp_data  = resp_data_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized and directed bench for shift_arbiter against a cycle-level behavioural model.
module tb_shift_arbiter;
  logic        clk = 0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_a, req1_a;
  logic [4:0]  req0_b, req1_b;
  logic        resp_valid, resp_port, resp_ready;
  logic [31:0] resp_data;

  int checks = 0;
  int errors = 0;

  // model state
  logic        m_valid, m_port, m_last;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  shift_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_port(resp_port), .resp_data(resp_data), .resp_ready(resp_ready)
  );

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a, input logic [4:0] b);
    logic [63:0] pow, prod;
    logic [31:0] q, fill;
    pow  = 64'd1 << b;
    prod = {32'd0, a} * pow;
    q    = 32'(({32'd0, a}) / pow);
    fill = ~32'(64'hFFFF_FFFF / pow);
    if (op == 2'b00) return prod[31:0];
    if (op == 2'b01) return q;
    return a[31] ? (q | fill) : q;
  endfunction

  function automatic int m_winner();
    if (req0_valid && req1_valid) begin
`ifdef SHIFT_ARB_RR_EN
      return (m_last == 1'b1) ? 0 : 1;
`else
      return 0;
`endif
    end
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic logic exp_rdy(input int n);
    return !reset && (!m_valid || resp_ready) && (m_winner() == n);
  endfunction

  // advance one clock and move the model across the same edge
  task automatic tick();
    logic nv, np, nl;
    logic [31:0] nd;
    int w;
    nv = m_valid; np = m_port; nl = m_last; nd = m_data;
    w = m_winner();
    if (reset) begin
      nv = 0; np = 0; nl = 1; nd = 0;
    end else if (!m_valid || resp_ready) begin
      if (w == 0) begin
        nv = 1; np = 0; nl = 0; nd = ref_shift(req0_op, req0_a, req0_b);
      end else if (w == 1) begin
        nv = 1; np = 1; nl = 1; nd = ref_shift(req1_op, req1_a, req1_b);
      end else nv = 0;
    end
    @(posedge clk); #1;
    m_valid = nv; m_port = np; m_last = nl; m_data = nd;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    resp_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    req0_valid = 1; req1_valid = 1;
    reset = 1; #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 00", req1_ready, req0_ready); end
    tick(); tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", resp_valid); end
    checks++; if (resp_port !== 1'b0) begin errors++; $display("FAIL reset_port got %b exp 0", resp_port); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", resp_data); end
    reset = 0; idle_inputs(); tick();
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1; req0_op = 2'b00; req0_a = 32'h1; req0_b = 5'd3; #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", req0_ready); end
    tick(); idle_inputs();
    checks++; if (resp_valid !== 1'b1 || resp_port !== 1'b0 || resp_data !== 32'h8)
      begin errors++; $display("FAIL single_resp got v%b p%b %h exp v1 p0 00000008", resp_valid, resp_port, resp_data); end
    tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", resp_valid); end
  endtask

  task automatic test_port1_seq();
    logic [1:0]  ops [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] as  [3] = '{32'h8000_0000, 32'h8000_0000, 32'hF000_0000};
    logic [4:0]  bs  [3] = '{5'd4, 5'd4, 5'd31};
    logic [31:0] exp [3] = '{32'hF800_0000, 32'h0800_0000, 32'hFFFF_FFFF};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req1_valid = 1; req1_op = ops[i]; req1_a = as[i]; req1_b = bs[i];
      tick();
      checks++; if (resp_valid !== 1'b1 || resp_port !== 1'b1 || resp_data !== exp[i])
        begin errors++; $display("FAIL p1_seq%0d got v%b p%b %h exp v1 p1 %h", i, resp_valid, resp_port, resp_data, exp[i]); end
    end
    idle_inputs(); tick();
  endtask

  task automatic test_both();
    logic ep;
    do_reset();
    req0_valid = 1; req0_op = 2'b01; req0_a = 32'h100; req0_b = 5'd1;
    req1_valid = 1; req1_op = 2'b00; req1_a = 32'h3;   req1_b = 5'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef SHIFT_ARB_RR_EN
      ep = i[0];
`else
      ep = 1'b0;
`endif
      checks++; if (resp_valid !== 1'b1 || resp_port !== ep || resp_data !== (ep ? 32'hC : 32'h80))
        begin errors++; $display("FAIL both%0d got p%b %h exp p%b", i, resp_port, resp_data, ep); end
    end
    req0_valid = 0; tick();
    checks++; if (resp_port !== 1'b1 || resp_data !== 32'hC) begin errors++; $display("FAIL both_p1 got p%b %h exp p1 0000000c", resp_port, resp_data); end
    idle_inputs(); tick();
  endtask

  task automatic test_stall();
    do_reset();
    req0_valid = 1; req0_op = 2'b00; req0_a = 32'h0000_00F0; req0_b = 5'd4;
    tick();
    resp_ready = 0; req0_a = 32'h0000_0005; req0_b = 5'd8; req1_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL stall_rdy%0d got %b%b exp 00", i, req1_ready, req0_ready); end
      tick();
      checks++; if (resp_valid !== 1'b1 || resp_port !== 1'b0 || resp_data !== 32'h0F00)
        begin errors++; $display("FAIL stall_hold%0d got v%b p%b %h exp v1 p0 00000f00", i, resp_valid, resp_port, resp_data); end
    end
    resp_ready = 1; #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL stall_release_rdy got %b exp 1", req0_ready); end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h0500) begin errors++; $display("FAIL stall_next got v%b %h exp v1 00000500", resp_valid, resp_data); end
    idle_inputs(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req1_valid = 1; req1_op = 2'b01; req1_a = 32'hFFFF; req1_b = 5'd4;
    tick();
    resp_ready = 0; req0_valid = 1; req0_op = 2'b00; req0_a = 32'h1; req0_b = 5'd1;
    reset = 1; #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL rmid_rdy got %b%b exp 00", req1_ready, req0_ready); end
    tick(); reset = 0;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", resp_valid); end
    resp_ready = 1; #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rmid_grant got %b%b exp 01", req1_ready, req0_ready); end
    tick();
    checks++; if (resp_port !== 1'b0 || resp_data !== 32'h2) begin errors++; $display("FAIL rmid_first got p%b %h exp p0 00000002", resp_port, resp_data); end
    idle_inputs(); tick();
  endtask

  task automatic test_zero_amt();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1; req0_op = 2'(i); req0_a = 32'hDEAD_BEEF; req0_b = 5'd0;
      tick();
      checks++; if (resp_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zero_op%0d got %h exp deadbeef", i, resp_data); end
    end
    idle_inputs(); tick();
  endtask

  task automatic test_random();
    logic a0, a1;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!req0_valid && $urandom_range(0, 2) != 0) begin
        req0_valid = 1; req0_op = 2'($urandom); req0_a = $urandom; req0_b = 5'($urandom);
      end
      if (!req1_valid && $urandom_range(0, 2) != 0) begin
        req1_valid = 1; req1_op = 2'($urandom); req1_a = $urandom; req1_b = 5'($urandom);
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 99) == 0);
      #1;
      checks++; if (req0_ready !== exp_rdy(0) || req1_ready !== exp_rdy(1))
        begin errors++; $display("FAIL rnd_rdy c%0d got %b%b exp %b%b", c, req1_ready, req0_ready, exp_rdy(1), exp_rdy(0)); end
      a0 = req0_valid && exp_rdy(0);
      a1 = req1_valid && exp_rdy(1);
      tick();
      reset = 0;
      if (a0) req0_valid = 0;
      if (a1) req1_valid = 0;
      checks++; if (resp_valid !== m_valid) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, resp_valid, m_valid); end
      if (m_valid) begin
        checks++; if (resp_port !== m_port || resp_data !== m_data)
          begin errors++; $display("FAIL rnd_resp c%0d got p%b %h exp p%b %h", c, resp_port, resp_data, m_port, m_data); end
      end
    end
    idle_inputs(); tick();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    m_valid = 0; m_port = 0; m_last = 1; m_data = 0;
    test_reset();
    test_single();
    test_port1_seq();
    test_both();
    test_stall();
    test_reset_mid();
    test_zero_amt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares the single 32-bit general shifter (SLL/SRL/SRA) between two requesters in the multi-stage processor: port 0 is the execute-stage ALU path, port 1 is the multi-cycle unit (mult/foureach sequencing). The arbiter accepts one request per cycle under valid/ready handshakes and drives the operands into the shifter. It registers the result with a port tag into a single output stage that has backpressure. Arbitration is round-robin or fixed-priority, selected at compile time.

## Interface
Parameters:
- None. Widths are fixed by the shifter: 32-bit data, 5-bit shift amount, 2-bit opcode.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 request valid.
- req0_op  in  2  port 0 opcode: 00 SLL, 01 SRL, 1x SRA.
- req0_a  in  32  port 0 operand.
- req0_b  in  5  port 0 shift amount.
- req0_ready  out  1  port 0 request accepted this cycle when high together with req0_valid.
- req1_valid, req1_op, req1_a, req1_b, req1_ready  same as port 0, for port 1.
- resp_valid  out  1  result register holds a valid result.
- resp_port  out  1  port that issued the held result.
- resp_data  out  32  shifter result.
- resp_ready  in  1  consumer takes the result when high with resp_valid.

## Operation
- Single clock domain. Reset is synchronous and active-high, as already decided.
- Instantiate the existing shifter. Its inputs come from a mux selected by the winning port.
- slot_free = !resp_valid || resp_ready.
- grant0/grant1 are combinational from req*_valid and the priority state. At most one grant is high.
- reqN_ready = grantN && slot_free. Ready may depend on valid. A requester must not make valid depend on ready.
- Transfer on port N: reqN_valid && reqN_ready. On a transfer, the next resp_data = shift(opN, aN, bN), resp_port = N, and resp_valid = 1.
- No transfer while slot_free: resp_valid is cleared if resp_ready drained it. Otherwise it stays 0.
- Stall (resp_valid && !resp_ready): resp_data and resp_port hold stable. Both readys are 0.
- Opcode 11 behaves as SRA, because op[1] selects the SRA path.
- Shift semantics: SLL and SRL zero-fill. SRA replicates a[31]. A shift amount of 0 passes a through unchanged.
- Priority state last_grant (1 bit) updates only on a transfer, to the port that transferred.

## Timing
- Latency is 1 cycle. A request accepted at edge N gives resp_valid high after edge N, with data from the operands sampled at edge N.
- Throughput is 1 result per cycle when resp_ready is held high. Drain and accept happen on the same edge with no bubble.
- Reset values: resp_valid=0, resp_port=0, resp_data=0, last_grant=1 (port 0 has first priority). req0_ready and req1_ready are 0 during reset.
- Reset mid-operation: a held result is discarded and no transfer occurs in the reset cycle. Normal operation resumes on the first cycle with reset low.
- Simultaneous valid on both ports: exactly one wins, per Configuration. The loser keeps valid high and waits.
- A request arriving while stalled waits and does not affect last_grant.

## Configuration
- SHIFT_ARB_RR_EN defined: round-robin arbitration.
  - Both ports valid: the port != last_grant wins.
  - Only one port valid: that port wins, regardless of last_grant.
- SHIFT_ARB_RR_EN undefined: fixed priority, port 0 always wins.
  - last_grant is still maintained but does not affect grants.
  - Port 1 is served only in cycles where req0_valid=0.

## Test plan
- Reset, then a single port-0 request SLL a=0x0000_0001, b=3, resp_ready=1 → one cycle later resp_valid=1, resp_port=0, resp_data=0x0000_0008. resp_valid=0 on the following cycle.
- Port 1 requests SRA a=0x8000_0000, b=4, then SRL with the same a and b, then op=11 with a=0xF000_0000, b=31 → results 0xF800_0000, 0x0800_0000, 0xFFFF_FFFF, all with resp_port=1, on back-to-back cycles.
- Both ports valid continuously with SHIFT_ARB_RR_EN defined and resp_ready=1 → resp_port sequence 0,1,0,1 from reset. Without the macro → 0,0,0,0, and port 1 is served only after req0_valid drops.
- Hold resp_ready=0 for 3 cycles after one result → resp_data/resp_port stay stable, both readys stay 0, and pending operands stay queued. Raising resp_ready drains the held result and accepts the next request on the same edge.
- Assert reset for 1 cycle while resp_valid=1 and both ports are valid → after the reset cycle resp_valid=0, no stale result appears, and the first grant goes to port 0.
- Shift amount 0 on each opcode with a=0xDEAD_BEEF → resp_data=0xDEAD_BEEF in all three cases.
